// File: rtl/rca_pkg.sv
// Shared constants and helpers for the pipelined ripple-carry adder.
package rca_pkg;

    localparam int WIDTH_DEF  = 32;
    localparam int STAGES_DEF = 4;

    function automatic int chunk_width(input int width, input int stages);
        return width / stages;
    endfunction

endpackage

// File: rtl/rca_chunk.sv
// Combinational C-bit ripple-carry adder used as one pipeline stage's carry chain.
module rca_chunk #(
    parameter int C = 8
) (
    input  logic [C-1:0] a,
    input  logic [C-1:0] b,
    input  logic         cin,
    output logic [C-1:0] sum,
    output logic         cout
);

    always_comb begin
        logic c;
        c   = cin;
        sum = '0;
        for (int i = 0; i < C; i++) begin
            sum[i] = a[i] ^ b[i] ^ c;
            c      = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
        end
        cout = c;
    end

endmodule

// File: rtl/rca_pipe.sv
// Pipelined add/subtract: one C-bit ripple chunk per stage, carry registered
// between stages, with a valid/ready handshake that freezes the whole pipe on stall.
module rca_pipe
    import rca_pkg::*;
#(
    parameter int WIDTH  = WIDTH_DEF,
    parameter int STAGES = STAGES_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int C = chunk_width(WIDTH, STAGES);
    localparam int L = STAGES - 1;

    if ((WIDTH % STAGES) != 0 || STAGES < 1 || STAGES > WIDTH) begin : g_param_check
        $error("rca_pipe: WIDTH must be a multiple of STAGES and 1 <= STAGES <= WIDTH");
    end

    logic             vld_q [STAGES];
    logic             cy_q  [STAGES];
    logic [WIDTH-1:0] acc_q [STAGES];
    logic [WIDTH-1:0] opa_q [STAGES];
    logic [WIDTH-1:0] opb_q [STAGES];
    logic             advance;

    // The whole pipe moves together, so bubbles keep their slots during a stall.
    assign out_valid = vld_q[L];
    assign advance   = !out_valid || out_ready;
    assign in_ready  = advance;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        logic             v_in;
        logic             c_in;
        logic [WIDTH-1:0] a_in;
        logic [WIDTH-1:0] b_in;
        logic [WIDTH-1:0] acc_in;
        logic [WIDTH-1:0] acc_nx;
        logic [C-1:0]     s_chunk;
        logic             c_out;

        if (k == 0) begin : g_first
            // Subtraction is a + ~b + 1; the +1 rides in on the stage-0 carry.
            assign v_in   = in_valid;
            assign a_in   = a;
            assign b_in   = sub ? ~b : b;
            assign c_in   = sub | cin;
            assign acc_in = '0;
        end else begin : g_next
            assign v_in   = vld_q[k-1];
            assign a_in   = opa_q[k-1];
            assign b_in   = opb_q[k-1];
            assign c_in   = cy_q[k-1];
            assign acc_in = acc_q[k-1];
        end

        rca_chunk #(.C(C)) u_chunk (
            .a    (a_in[k*C +: C]),
            .b    (b_in[k*C +: C]),
            .cin  (c_in),
            .sum  (s_chunk),
            .cout (c_out)
        );

        always_comb begin
            acc_nx            = acc_in;
            acc_nx[k*C +: C]  = s_chunk;
        end

        always_ff @(posedge clk) begin
            if (!rst_n) begin
                vld_q[k] <= 1'b0;
                cy_q[k]  <= 1'b0;
                acc_q[k] <= '0;
                opa_q[k] <= '0;
                opb_q[k] <= '0;
            end else if (advance) begin
                vld_q[k] <= v_in;
                cy_q[k]  <= c_out;
                acc_q[k] <= acc_nx;
                opa_q[k] <= a_in;
                opb_q[k] <= b_in;
            end
        end
    end

    // Overflow is derived from the last stage's registered operand MSBs; all zero after reset.
    assign sum  = acc_q[L];
    assign cout = cy_q[L];
    assign ovf  = (opa_q[L][WIDTH-1] == opb_q[L][WIDTH-1]) && (acc_q[L][WIDTH-1] != opa_q[L][WIDTH-1]);

endmodule
